jump_target_unit: RTL and testbench



---
 rtl/jump_target_unit_if.sv | 43 ++++
 rtl/jump_target_unit.sv | 83 ++++++++
 tb/tb_jump_target_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/jump_target_unit_if.sv
// Handshake bundle between ID, the jump target unit and the IF PC-select mux.
// misalign_err is present only when ALIGN_CHECK_EN is defined.
interface jump_target_unit_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic              in_taken;
    logic [ADDR_W-1:0] in_pc_plus4;
    logic [IDX_W-1:0]  in_index;
    logic [IMM_W-1:0]  in_imm;
    logic [ADDR_W-1:0] in_reg;
    logic              flush;
    logic              redir_valid;
    logic              redir_ready;
    logic [ADDR_W-1:0] redir_target;
    logic [CNT_W-1:0]  redir_count;
`ifdef ALIGN_CHECK_EN
    logic              misalign_err;
`endif

    modport master (
`ifdef ALIGN_CHECK_EN
        input  misalign_err,
`endif
        output in_valid, in_kind, in_taken, in_pc_plus4, in_index, in_imm, in_reg,
        output flush, redir_ready,
        input  in_ready, redir_valid, redir_target, redir_count
    );

    modport slave (
`ifdef ALIGN_CHECK_EN
        output misalign_err,
`endif
        input  in_valid, in_kind, in_taken, in_pc_plus4, in_index, in_imm, in_reg,
        input  flush, redir_ready,
        output in_ready, redir_valid, redir_target, redir_count
    );
endinterface

// File: rtl/jump_target_unit.sv
// Control-transfer target computation with a single-entry redirect buffer toward fetch.
// Define ALIGN_CHECK_EN to reject misaligned JR targets and raise misalign_err.
module jump_target_unit #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    jump_target_unit_if.slave bus
);
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_BRANCH = 2'b10;
    localparam logic [1:0] KIND_REG    = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              accept;
    logic              misaligned;
    logic              redirectNeeded;
    logic              handshakeDone;
    logic [ADDR_W-1:0] immExt;
    logic [ADDR_W-1:0] jumpTarget;
    logic [ADDR_W-1:0] branchTarget;
    logic [ADDR_W-1:0] nextTarget;

    assign bus.in_ready  = !bus.flush && (!bus.redir_valid || bus.redir_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign handshakeDone = bus.redir_valid && bus.redir_ready && !bus.flush;

    assign immExt       = {{(ADDR_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
    assign branchTarget = bus.in_pc_plus4 + {immExt[ADDR_W-3:0], 2'b00};
    assign jumpTarget   = {bus.in_pc_plus4[ADDR_W-1:IDX_W+2], bus.in_index, 2'b00};

    always_comb begin
        misaligned = 1'b0;
`ifdef ALIGN_CHECK_EN
        misaligned = (bus.in_kind == KIND_REG) && (bus.in_reg[1:0] != 2'b00);
`endif
    end

    always_comb begin
        case (bus.in_kind)
            KIND_JUMP:   nextTarget = jumpTarget;
            KIND_BRANCH: nextTarget = branchTarget;
            default:     nextTarget = bus.in_reg;
        endcase
    end

    // A misaligned JR is accepted but treated like a not-taken branch.
    assign redirectNeeded = (bus.in_kind == KIND_JUMP)
                         || ((bus.in_kind == KIND_REG) && !misaligned)
                         || ((bus.in_kind == KIND_BRANCH) && bus.in_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.redir_valid  <= 1'b0;
            bus.redir_target <= '0;
            bus.redir_count  <= '0;
`ifdef ALIGN_CHECK_EN
            bus.misalign_err <= 1'b0;
`endif
        end else begin
            if (handshakeDone && (bus.redir_count != CNT_MAX)) begin
                bus.redir_count <= bus.redir_count + 1'b1;
            end

            // in_ready is low during flush, so accept cannot coincide with it.
            if (bus.flush) begin
                bus.redir_valid <= 1'b0;
            end else if (accept && redirectNeeded) begin
                bus.redir_valid  <= 1'b1;
                bus.redir_target <= nextTarget;
            end else if (bus.redir_ready) begin
                bus.redir_valid <= 1'b0;
            end

`ifdef ALIGN_CHECK_EN
            bus.misalign_err <= accept && misaligned;
`endif
        end
    end
endmodule

// File: tb/tb_jump_target_unit.sv
// Directed and randomized checks of jump_target_unit against a transaction-level reference.
// Build with ALIGN_CHECK_EN defined to exercise the misalignment path.
module tb_jump_target_unit;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 26;
    localparam int IMM_W  = 16;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        mValid;
    logic [31:0] mTarget;
    int          mCount;
    logic        mMis;

    jump_target_unit_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    jump_target_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference target computed with plain integer arithmetic.
    function automatic logic [31:0] refTarget(input logic [1:0] k, input logic [31:0] pc,
                                              input logic [25:0] idx, input logic [15:0] imm,
                                              input logic [31:0] rg);
        longint p;
        longint region;
        longint off;
        p = longint'(pc);
        region = longint'(1) << (IDX_W + 2);
        case (k)
            2'd1: return 32'((p / region) * region + longint'(idx) * 4);
            2'd2: begin
                off = imm[15] ? longint'(imm) - 65536 : longint'(imm);
                return 32'(p + off * 4);
            end
            default: return rg;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] k, input logic tk, input logic [31:0] pc,
                         input logic [25:0] idx, input logic [15:0] imm, input logic [31:0] rg,
                         input logic rdy, input logic fl);
        bus.in_valid    = v;
        bus.in_kind     = k;
        bus.in_taken    = tk;
        bus.in_pc_plus4 = pc;
        bus.in_index    = idx;
        bus.in_imm      = imm;
        bus.in_reg      = rg;
        bus.redir_ready = rdy;
        bus.flush       = fl;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 16'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic checkOutputs(input string where);
        chk({where, "_valid"}, bus.redir_valid, mValid);
        chk({where, "_target"}, bus.redir_target, mTarget);
        chk({where, "_count"}, bus.redir_count, mCount);
`ifdef ALIGN_CHECK_EN
        chk({where, "_misalign"}, bus.misalign_err, mMis);
`endif
    endtask

    // One clock: check in_ready, predict the edge outcome, then compare registered outputs.
    task automatic cycle(input string where);
        logic expReady, acc, need, mis, nValid;
        logic [31:0] nTarget;
        int nCount;
        #1;
        expReady = !bus.flush && (!mValid || bus.redir_ready);
        chk({where, "_in_ready"}, bus.in_ready, expReady);
        acc = bus.in_valid && expReady;
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = acc && (bus.in_kind == 2'd3) && (bus.in_reg[1:0] != 2'b00);
`endif
        need = (bus.in_kind == 2'd1) || (bus.in_kind == 2'd3 && !mis)
            || (bus.in_kind == 2'd2 && bus.in_taken);
        nCount = mCount;
        if (mValid && bus.redir_ready && !bus.flush && mCount < CNT_MAX) nCount = mCount + 1;
        nValid  = mValid;
        nTarget = mTarget;
        if (bus.flush) nValid = 1'b0;
        else if (acc && need) begin
            nValid  = 1'b1;
            nTarget = refTarget(bus.in_kind, bus.in_pc_plus4, bus.in_index, bus.in_imm, bus.in_reg);
        end else if (bus.redir_ready) nValid = 1'b0;
        @(posedge clk);
        #1;
        mValid  = nValid;
        mTarget = nTarget;
        mCount  = nCount;
        mMis    = mis;
        checkOutputs(where);
    endtask

    task automatic clearModel();
        mValid  = 1'b0;
        mTarget = '0;
        mCount  = 0;
        mMis    = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(1'b0);
        clearModel();
        #1;
        checkOutputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        clearModel();
        doReset();

        // Jump: region concat
        drive(1'b1, 2'd1, 1'b0, 32'h9000_0004, 26'h100, 16'h0, 32'h0, 1'b0, 1'b0);
        cycle("jump");
        chk("jump_const_valid", bus.redir_valid, 1'b1);
        chk("jump_const_target", bus.redir_target, 32'h9000_0400);
        idle(1'b1);
        cycle("jump_consume");
        chk("jump_count", bus.redir_count, 1);

        // Branch backward with wrap, then not-taken
        drive(1'b1, 2'd2, 1'b1, 32'h0000_0004, 26'h0, 16'hFFFE, 32'h0, 1'b0, 1'b0);
        cycle("br_taken");
        chk("br_const_target", bus.redir_target, 32'hFFFF_FFFC);
        idle(1'b1);
        cycle("br_consume");
        drive(1'b1, 2'd2, 1'b0, 32'h0000_0004, 26'h0, 16'hFFFE, 32'h0, 1'b0, 1'b0);
        cycle("br_not_taken");
        chk("br_nt_valid", bus.redir_valid, 1'b0);

        // Backpressure then back-to-back JR
        doReset();
        drive(1'b1, 2'd1, 1'b0, 32'h9000_0004, 26'h100, 16'h0, 32'h0, 1'b0, 1'b0);
        cycle("bp_load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 16'h0, 32'h1234_5678, 1'b0, 1'b0);
            cycle("bp_stall");
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_stable_target", bus.redir_target, 32'h9000_0400);
        end
        drive(1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 16'h0, 32'h0040_0020, 1'b1, 1'b0);
        cycle("bp_b2b");
        chk("b2b_valid", bus.redir_valid, 1'b1);
        chk("b2b_target", bus.redir_target, 32'h0040_0020);
        idle(1'b1);
        cycle("bp_drain");
        chk("bp_count", bus.redir_count, 2);

        // Flush wins over ready; same-cycle input dropped
        drive(1'b1, 2'd1, 1'b0, 32'h9000_0004, 26'h3, 16'h0, 32'h0, 1'b0, 1'b0);
        cycle("fl_load");
        drive(1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 16'h0, 32'h0000_0100, 1'b1, 1'b1);
        cycle("flush");
        chk("flush_valid", bus.redir_valid, 1'b0);
        chk("flush_count", bus.redir_count, 2);

        // Counter saturation then asynchronous reset mid-cycle
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 1'b0, 32'h1000_0004, 26'(i), 16'h0, 32'h0, 1'b1, 1'b0);
            cycle("sat_b2b");
        end
        idle(1'b1);
        cycle("sat_drain");
        chk("sat_count", bus.redir_count, 3);
        drive(1'b1, 2'd1, 1'b0, 32'h1000_0004, 26'h7, 16'h0, 32'h0, 1'b0, 1'b0);
        cycle("async_load");
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", bus.redir_valid, 1'b0);
        chk("async_target", bus.redir_target, 32'h0);
        chk("async_count", bus.redir_count, 0);
        clearModel();
        idle(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // JR with low address bits set
        drive(1'b1, 2'd3, 1'b0, 32'h0, 26'h0, 16'h0, 32'h0040_0022, 1'b0, 1'b0);
        cycle("jr_low");
`ifdef ALIGN_CHECK_EN
        chk("align_no_redirect", bus.redir_valid, 1'b0);
        chk("align_err_pulse", bus.misalign_err, 1'b1);
        idle(1'b0);
        cycle("align_after");
        chk("align_err_clear", bus.misalign_err, 1'b0);
`else
        chk("jr_low_target", bus.redir_target, 32'h0040_0022);
        chk("jr_low_valid", bus.redir_valid, 1'b1);
`endif

        // Randomized traffic
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rg;
            rg = $urandom;
            if ($urandom_range(0, 1) == 0) rg[1:0] = 2'b00;
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  $urandom, 26'($urandom), 16'($urandom), rg,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
